pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline (fetch, decode, execute, memory, writeback). It consumes hazard-relevant stage fields and the I/D cache hit strobes. It drives per-latch enable and flush signals plus the PC enable, so the forwarding unit only ever sees legal operand pairs. It resolves load-use, jr-on-load, memory-wait, taken-branch and halt-drain cases with a small FSM and a stall counter.

---
 rtl/pipeline_hazard_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush sequencer for a 5-stage pipeline. Decides the
//               per-latch enables, bubble injection and PC enable from the
//               hazard fields of each stage and the I/D cache hit strobes.
//               Optional macro HAZARD_PERF_CNT_EN adds stall_cnt/flush_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int REG_W         = 5,
  parameter int JR_LOAD_STALL = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] rs_de,
  input  logic [REG_W-1:0] rt_de,
  input  logic             useRt_de,
  input  logic             jr_de,
  input  logic [REG_W-1:0] regDst_ex,
  input  logic             regWr_ex,
  input  logic             memRead_ex,
  input  logic [REG_W-1:0] regDst_me,
  input  logic             regWr_me,
  input  logic             memRead_me,
  input  logic             dREN_me,
  input  logic             dWEN_me,
  input  logic             brTaken_me,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             en_fd,
  output logic             en_de,
  output logic             en_em,
  output logic             en_mw,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             flush_em,
  output logic             halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  // Counter holds the JRWAIT cycles still owed after the first stall cycle.
  localparam int CNT_W = (JR_LOAD_STALL > 2) ? $clog2(JR_LOAD_STALL) : 1;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_JRWAIT  = 2'd1,
    S_MEMWAIT = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic w_match_ex, w_match_me, w_mem_miss;
  logic w_load_use, w_jr_ex, w_jr_me;
  logic w_pc_en, w_en_fd, w_en_de, w_en_em, w_en_mw;
  logic w_flush_fd, w_flush_de, w_flush_em;
  logic w_flush_evt;

  // Register 0 is hardwired, so a write to it is never a real dependency.
  assign w_match_ex = regWr_ex && (regDst_ex != '0) &&
                      ((rs_de == regDst_ex) || (useRt_de && (rt_de == regDst_ex)));
  assign w_match_me = regWr_me && (regDst_me != '0) &&
                      ((rs_de == regDst_me) || (useRt_de && (rt_de == regDst_me)));
  assign w_mem_miss = (dREN_me || dWEN_me) && !dhit;
  assign w_load_use = memRead_ex && w_match_ex && !jr_de;
  assign w_jr_ex    = jr_de && w_match_ex && memRead_ex;
  assign w_jr_me    = jr_de && w_match_me && memRead_me;

  // Next-state and raw enable/flush decode, prioritised per state.
  always_comb begin
    w_pc_en     = 1'b1;
    w_en_fd     = 1'b1;
    w_en_de     = 1'b1;
    w_en_em     = 1'b1;
    w_en_mw     = 1'b1;
    w_flush_fd  = 1'b0;
    w_flush_de  = 1'b0;
    w_flush_em  = 1'b0;
    w_flush_evt = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_HALTED: begin
        {w_pc_en, w_en_fd, w_en_de, w_en_em, w_en_mw} = '0;
      end
      S_JRWAIT: begin
        if (halt_wb) begin
          {w_pc_en, w_en_fd, w_en_de, w_en_em, w_en_mw} = '0;
          w_state_nxt = S_HALTED;
        end else if (w_mem_miss) begin
          // Whole pipe frozen; the jr countdown resumes once memory answers.
          {w_pc_en, w_en_fd, w_en_de, w_en_em, w_en_mw} = '0;
        end else if (brTaken_me) begin
          {w_flush_fd, w_flush_de, w_flush_em} = 3'b111;
          w_flush_evt = 1'b1;
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_pc_en    = 1'b0;
          w_en_fd    = 1'b0;
          w_flush_de = 1'b1;
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end
      default: begin
        if (halt_wb) begin
          {w_pc_en, w_en_fd, w_en_de, w_en_em, w_en_mw} = '0;
          w_state_nxt = S_HALTED;
        end else if ((r_state == S_MEMWAIT) ? !dhit : w_mem_miss) begin
          // Fetch misses are ignored here: memory must finish first.
          {w_pc_en, w_en_fd, w_en_de, w_en_em, w_en_mw} = '0;
          w_state_nxt = S_MEMWAIT;
        end else begin
          w_state_nxt = S_RUN;
          if (brTaken_me) begin
            {w_flush_fd, w_flush_de, w_flush_em} = 3'b111;
            w_flush_evt = 1'b1;
          end else if (w_load_use || w_jr_ex || w_jr_me) begin
            w_pc_en    = 1'b0;
            w_en_fd    = 1'b0;
            w_flush_de = 1'b1;
            // The first jr-on-load stall is this cycle; JRWAIT covers the rest.
            if (w_jr_ex && (JR_LOAD_STALL > 1)) begin
              w_state_nxt = S_JRWAIT;
              w_cnt_nxt   = CNT_W'(JR_LOAD_STALL - 1);
            end
          end else if (!ihit) begin
            w_pc_en    = 1'b0;
            w_flush_fd = 1'b1;
          end
        end
      end
    endcase
  end

  // Reset forces a frozen, fully-bubbled pipe regardless of state.
  always_comb begin
    pc_en    = w_pc_en  && !RST;
    en_fd    = w_en_fd  && !RST;
    en_de    = w_en_de  && !RST;
    en_em    = w_en_em  && !RST;
    en_mw    = w_en_mw  && !RST;
    flush_fd = w_flush_fd || RST;
    flush_de = w_flush_de || RST;
    flush_em = w_flush_em || RST;
    halted   = (r_state == S_HALTED) && !RST;
  end

  // State and jr stall counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic        w_stall_evt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  assign w_stall_evt = !w_pc_en && (r_state != S_HALTED);
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

  // Saturating performance counters, frozen once halted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (r_state != S_HALTED) begin
      if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush_evt && (r_flush_cnt != 32'hFFFF_FFFF))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ihit, dhit, useRt_de, jr_de;
  logic [4:0] rs_de, rt_de, regDst_ex, regDst_me;
  logic       regWr_ex, memRead_ex, regWr_me, memRead_me;
  logic       dREN_me, dWEN_me, brTaken_me, halt_wb;
  logic       pc_en, en_fd, en_de, en_em, en_mw;
  logic       flush_fd, flush_de, flush_em, halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  // {pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, halted}
  localparam logic [8:0] E_RESET  = 9'b00000_111_0;
  localparam logic [8:0] E_NORMAL = 9'b11111_000_0;
  localparam logic [8:0] E_LDUSE  = 9'b00111_010_0;
  localparam logic [8:0] E_FREEZE = 9'b00000_000_0;
  localparam logic [8:0] E_BRANCH = 9'b11111_111_0;
  localparam logic [8:0] E_IMISS  = 9'b01111_100_0;
  localparam logic [8:0] E_HALTED = 9'b00000_000_1;

  pipeline_hazard_ctrl #(.REG_W(5), .JR_LOAD_STALL(2)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .rs_de(rs_de), .rt_de(rt_de), .useRt_de(useRt_de), .jr_de(jr_de),
    .regDst_ex(regDst_ex), .regWr_ex(regWr_ex), .memRead_ex(memRead_ex),
    .regDst_me(regDst_me), .regWr_me(regWr_me), .memRead_me(memRead_me),
    .dREN_me(dREN_me), .dWEN_me(dWEN_me), .brTaken_me(brTaken_me),
    .halt_wb(halt_wb),
    .pc_en(pc_en), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
    .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em),
    .halted(halted)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1; useRt_de = 1'b0; jr_de = 1'b0;
    rs_de = '0; rt_de = '0; regDst_ex = '0; regDst_me = '0;
    regWr_ex = 1'b0; memRead_ex = 1'b0; regWr_me = 1'b0; memRead_me = 1'b0;
    dREN_me = 1'b0; dWEN_me = 1'b0; brTaken_me = 1'b0; halt_wb = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    #1;
    obs = {pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, halted};
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic load_in_ex(input logic [4:0] rd);
    regDst_ex = rd; regWr_ex = 1'b1; memRead_ex = 1'b1;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    chk("reset_c0", E_RESET);
    tick();
    chk("reset_c1", E_RESET);
    tick();
    RST = 1'b0;
    chk("post_reset", E_NORMAL);
    tick();

    // Load-use via rs, then register 0, then via rt
    load_in_ex(5'd5); rs_de = 5'd5;
    chk("lduse_rs", E_LDUSE);
    tick();
    idle();
    chk("lduse_after", E_NORMAL);
    tick();
    load_in_ex(5'd0); rs_de = 5'd0;
    chk("lduse_r0", E_NORMAL);
    tick();
    idle(); load_in_ex(5'd5); rs_de = 5'd3; rt_de = 5'd5; useRt_de = 1'b1;
    chk("lduse_rt", E_LDUSE);
    tick();
    useRt_de = 1'b0;
    chk("rt_unused", E_NORMAL);
    tick();

    // jr on load in execute, with a 3-cycle dmem miss inside the wait
    idle(); jr_de = 1'b1; rs_de = 5'd8; load_in_ex(5'd8);
    chk("jr_ex_s0", E_LDUSE);
    tick();
    regWr_ex = 1'b0; memRead_ex = 1'b0; regDst_ex = '0;
    regDst_me = 5'd8; regWr_me = 1'b1; memRead_me = 1'b1; dREN_me = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("jr_miss", E_FREEZE);
      tick();
    end
    dhit = 1'b1;
    chk("jr_wait_s1", E_LDUSE);
    tick();
    idle(); jr_de = 1'b1; rs_de = 5'd8;
    chk("jr_go", E_NORMAL);
    tick();

    // jr on load in memory: single stall, no state change
    idle(); jr_de = 1'b1; rs_de = 5'd9; regDst_me = 5'd9; regWr_me = 1'b1; memRead_me = 1'b1;
    chk("jr_me", E_LDUSE);
    tick();
    idle();
    chk("jr_me_after", E_NORMAL);
    tick();

    // Fetch miss alone, then fetch miss coincident with load-use
    ihit = 1'b0;
    chk("imiss", E_IMISS);
    tick();
    load_in_ex(5'd4); rs_de = 5'd4;
    chk("lduse_vs_imiss", E_LDUSE);
    tick();
    idle();

    // dmem miss for 4 cycles with taken branch held and fetch also missing
    dREN_me = 1'b1; dhit = 1'b0; brTaken_me = 1'b1; ihit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("memwait_br", E_FREEZE);
      tick();
    end
    dhit = 1'b1;
    chk("memdone_br", E_BRANCH);
    tick();
    idle();
    chk("after_br", E_NORMAL);
    tick();

    // Write miss, then deferred fetch miss on the completion cycle
    dWEN_me = 1'b1; dhit = 1'b0; ihit = 1'b0;
    chk("wmiss_c0", E_FREEZE);
    tick();
    chk("wmiss_c1", E_FREEZE);
    tick();
    dhit = 1'b1;
    chk("wmiss_done_imiss", E_IMISS);
    tick();
    idle();
    chk("wmiss_after", E_NORMAL);
    tick();

    // Taken branch while in JRWAIT returns to RUN
    jr_de = 1'b1; rs_de = 5'd7; load_in_ex(5'd7);
    chk("jr_br_s0", E_LDUSE);
    tick();
    idle(); brTaken_me = 1'b1;
    chk("jr_br_flush", E_BRANCH);
    tick();
    idle();
    chk("jr_br_after", E_NORMAL);
    tick();

    // Reset in the middle of a jr wait leaves nothing behind
    jr_de = 1'b1; rs_de = 5'd6; load_in_ex(5'd6);
    chk("jr_rst_s0", E_LDUSE);
    tick();
    idle(); RST = 1'b1;
    chk("jr_rst", E_RESET);
    tick();
    RST = 1'b0;
    chk("jr_rst_after", E_NORMAL);
    tick();

    // Halt is sticky across cache strobe activity until reset
    halt_wb = 1'b1;
    tick();
    halt_wb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ihit = i[0]; dhit = ~i[0]; brTaken_me = i[1];
      chk("halted", E_HALTED);
      tick();
    end
    idle(); RST = 1'b1;
    chk("halt_rst", E_RESET);
    tick();
    RST = 1'b0;
    chk("halt_cleared", E_NORMAL);
    tick();

`ifdef HAZARD_PERF_CNT_EN
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_chk++;
    assert (stall_cnt === 32'd0 && flush_cnt === 32'd0) else begin
      n_err++;
      $error("FAIL perf_reset: observed %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    load_in_ex(5'd5); rs_de = 5'd5;
    tick();
    idle();
    tick();
    brTaken_me = 1'b1;
    tick();
    brTaken_me = 1'b0;
    tick();
    brTaken_me = 1'b1;
    tick();
    idle();
    #1;
    n_chk++;
    assert (stall_cnt === 32'd1) else begin
      n_err++;
      $error("FAIL perf_stall: observed %0d expected 1", stall_cnt);
    end
    n_chk++;
    assert (flush_cnt === 32'd2) else begin
      n_err++;
      $error("FAIL perf_flush: observed %0d expected 2", flush_cnt);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
